// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: pixel stream input and framebuffer write bus of fb_pixel_writer.
interface fb_pixel_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 24
);
    logic                  pixel_valid;
    logic                  pixel_sof;
    logic [DATA_WIDTH-1:0] pixel_data;
    logic                  pixel_ready;
    logic                  bus_wen;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic                  bus_request_stall;
    logic                  bus_error;
    modport master (
        input  pixel_valid, pixel_sof, pixel_data, bus_request_stall, bus_error,
        output pixel_ready, bus_wen, bus_addr, bus_wdata
    );
    modport slave (
        output pixel_valid, pixel_sof, pixel_data, bus_request_stall, bus_error,
        input  pixel_ready, bus_wen, bus_addr, bus_wdata
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: writes a raster pixel stream into a framebuffer, one stallable write per pixel.
module fb_pixel_writer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 24,
    parameter int                    IMG_WIDTH  = 48,
    parameter int                    IMG_HEIGHT = 48,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                     ahb_clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr_status,
    fb_pixel_writer_if.master        bus,
    output logic                     frame_done,
    output logic [15:0]              frame_count,
    output logic                     busy,
    output logic                     err_sticky,
    output logic                     sof_early_sticky
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, use_idx;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           fc_q, fc_d;
    logic                  last_q, last_d;
    logic                  fd_q, fd_d;
    logic                  err_q, err_d;
    logic                  sof_q, sof_d;
    logic                  complete, ready, accept;

    always_comb begin
        complete = (state_q == WRITE) && !bus.bus_request_stall;
        ready    = en && !rst && ((state_q == IDLE) || complete);
        accept   = ready && bus.pixel_valid;
        use_idx  = bus.pixel_sof ? '0 : idx_q;
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        last_d   = last_q;
        if (accept) begin
            state_d = WRITE;
            idx_d   = (use_idx == LAST_IDX) ? '0 : use_idx + 1'b1;
            addr_d  = BASE_ADDR + ADDR_WIDTH'({use_idx, 2'b00});
            wdata_d = 32'(bus.pixel_data[DATA_WIDTH-1:0]);
            last_d  = (use_idx == LAST_IDX);
        end else if (complete) begin
            state_d = IDLE;
        end
        // the last pixel's completion yields a done pulse on the following cycle
        fd_d  = complete && last_q;
        fc_d  = fc_q + 16'(fd_d);
        err_d = (complete && bus.bus_error) || (err_q && !clr_status);
        sof_d = (accept && bus.pixel_sof && (idx_q != '0)) || (sof_q && !clr_status);
    end

    always_ff @(posedge ahb_clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            fd_q    <= 1'b0;
            fc_q    <= '0;
            err_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            fd_q    <= fd_d;
            fc_q    <= fc_d;
            err_q   <= err_d;
            sof_q   <= sof_d;
        end
    end

    assign bus.pixel_ready  = ready;
    assign bus.bus_wen      = (state_q == WRITE);
    assign bus.bus_addr     = addr_q;
    assign bus.bus_wdata    = wdata_q;
    assign busy             = (state_q == WRITE);
    assign frame_done       = fd_q;
    assign frame_count      = fc_q;
    assign err_sticky       = err_q;
    assign sof_early_sticky = sof_q;
endmodule
